// File: rtl/mac_dot_sequencer_pkg.sv
// Shared definitions for the dot-product sequencer: operand/result widths
// and the FSM state encoding.
package mac_dot_sequencer_pkg;

  localparam int OP_W  = 8;
  localparam int RES_W = 16;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ACCUM = 2'd1,
    S_DONE  = 2'd2
  } state_t;

endpackage

// File: rtl/mac_dot_sequencer_mac_unit.sv
// Multiply-accumulate datapath: the first enabled cycle loads a*b, and later
// cycles add a*b with 16-bit wrap and a sticky carry-out flag.
module mac_unit
  import mac_dot_sequencer_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic             clr_mult,
  input  logic [OP_W-1:0]  a,
  input  logic [OP_W-1:0]  b,
  output logic [RES_W-1:0] acc,
  output logic             ovf
);

  logic [RES_W-1:0] prod;
  logic [RES_W:0]   sum;

  // An 8x8 unsigned product always fits in 16 bits, so it is exact.
  assign prod = RES_W'(a) * RES_W'(b);
  assign sum  = {1'b0, acc} + {1'b0, prod};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc <= '0;
      ovf <= 1'b0;
    end else if (en) begin
      if (clr_mult) begin
        acc <= prod;
        ovf <= 1'b0;
      end else begin
        acc <= sum[RES_W-1:0];
        ovf <= ovf | sum[RES_W];
      end
    end
  end

endmodule

// File: rtl/mac_dot_sequencer.sv
// Dot-product sequencer: accepts a length command, accumulates that many
// operand pairs through mac_unit, then presents the result until it is taken.
module mac_dot_sequencer
  import mac_dot_sequencer_pkg::*;
#(
  parameter int LEN_W = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [LEN_W-1:0] len,
  output logic             cmd_ready,
  input  logic             abort,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [OP_W-1:0]  in_a,
  input  logic [OP_W-1:0]  in_b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [RES_W-1:0] out_result,
  output logic             out_ovf,
  output logic             busy,
  output logic [1:0]       dbg_state
);

  localparam int CNT_W = LEN_W + 1;

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   count_q;
  logic               first_q;
  logic               cmd_accept;
  logic               transfer;
  logic               last_xfer;
  logic [CNT_W-1:0]   len_count;

  // Handshakes: a beat moves on any rising edge where valid and ready are both
  // high. In ACCUM an asserted abort suppresses the operand beat even though
  // in_ready is high, so the operands are dropped and never accumulated.
  assign cmd_accept = (state_q == S_IDLE) && start;
  assign transfer   = (state_q == S_ACCUM) && in_valid && !abort;
  assign last_xfer  = transfer && (count_q == CNT_W'(1));
  assign len_count  = (len == '0) ? {1'b1, {LEN_W{1'b0}}} : {1'b0, len};

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: begin
        if (start) state_d = S_ACCUM;
      end
      S_ACCUM: begin
        if (abort)          state_d = S_IDLE;
        else if (last_xfer) state_d = S_DONE;
      end
      S_DONE: begin
        if (out_ready) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      count_q <= '0;
      first_q <= 1'b0;
    end else begin
      state_q <= state_d;
      if (cmd_accept) begin
        count_q <= len_count;
        first_q <= 1'b1;
      end else if (transfer) begin
        count_q <= count_q - CNT_W'(1);
        first_q <= 1'b0;
      end
    end
  end

  mac_unit u_mac (
    .clk      (clk),
    .rst_n    (rst_n),
    .en       (transfer),
    .clr_mult (first_q),
    .a        (in_a),
    .b        (in_b),
    .acc      (out_result),
    .ovf      (out_ovf)
  );

  assign cmd_ready = (state_q == S_IDLE);
  assign busy      = (state_q != S_IDLE);
  assign in_ready  = (state_q == S_ACCUM);
  assign out_valid = (state_q == S_DONE);
  assign dbg_state = state_q;

endmodule

// File: tb/tb_mac_dot_sequencer.sv
// Self-checking bench for mac_dot_sequencer: directed scenarios plus random
// dot products checked against an arithmetic reference model.
module tb_mac_dot_sequencer;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic [3:0]  len = '0;
  logic        cmd_ready;
  logic        abort = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [7:0]  in_a = '0;
  logic [7:0]  in_b = '0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [15:0] out_result;
  logic        out_ovf;
  logic        busy;
  logic [1:0]  dbg_state;

  int n_checks = 0;
  int n_fail   = 0;
  int pa[16];
  int pb[16];
  logic [16:0] exp_q[$];

  mac_dot_sequencer #(.LEN_W(4)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .len        (len),
    .cmd_ready  (cmd_ready),
    .abort      (abort),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_a       (in_a),
    .in_b       (in_b),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_result (out_result),
    .out_ovf    (out_ovf),
    .busy       (busy),
    .dbg_state  (dbg_state)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_reset_outputs(input string name);
    n_checks++;
    if (cmd_ready !== 1'b1 || in_ready !== 1'b0 || out_valid !== 1'b0 ||
        busy !== 1'b0 || out_result !== 16'h0 || out_ovf !== 1'b0) begin
      n_fail++;
      $display("FAIL %s: cmd_ready=%b in_ready=%b out_valid=%b busy=%b result=%h ovf=%b, required 1 0 0 0 0000 0",
               name, cmd_ready, in_ready, out_valid, busy, out_result, out_ovf);
    end
  endtask

  // Runs one full dot product over pa/pb. gap_mode: 0 none, 1 one idle cycle
  // before every pair after the first, 2 random idle cycles. hold = number of
  // cycles the result is left un-taken while start/abort are waved at the DUT.
  task automatic run_dot(input logic [3:0] l, input int gap_mode, input int hold, input string name);
    int n;
    int sum;
    int k;
    logic [16:0] e;
    n   = (l == 4'd0) ? 16 : int'(l);
    sum = 0;
    start = 1'b1;
    len   = l;
    tick();
    start = 1'b0;
    n_checks++;
    if (cmd_ready !== 1'b0 || busy !== 1'b1 || in_ready !== 1'b1 || out_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL %s_start: cmd_ready=%b busy=%b in_ready=%b out_valid=%b, required 0 1 1 0",
               name, cmd_ready, busy, in_ready, out_valid);
    end
    for (int i = 0; i < n; i++) begin
      k = (gap_mode == 1 && i > 0) ? 1 : (gap_mode == 2 ? int'($urandom_range(0, 2)) : 0);
      for (int j = 0; j < k; j++) begin
        in_valid = 1'b0;
        in_a = 8'($urandom);
        in_b = 8'($urandom);
        tick();
        if (i > 0) begin
          n_checks++;
          if (out_result !== 16'(sum) || out_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL %s_idle: result=%h out_valid=%b, required %h 0",
                     name, out_result, out_valid, 16'(sum));
          end
        end
      end
      in_valid = 1'b1;
      in_a = 8'(pa[i]);
      in_b = 8'(pb[i]);
      tick();
      in_valid = 1'b0;
      sum += pa[i] * pb[i];
      if (i < n - 1) begin
        n_checks++;
        if (out_valid !== 1'b0 || out_result !== 16'(sum)) begin
          n_fail++;
          $display("FAIL %s_partial%0d: out_valid=%b result=%h, required 0 %h",
                   name, i, out_valid, out_result, 16'(sum));
        end
      end
    end
    exp_q.push_back({(sum >= 65536) ? 1'b1 : 1'b0, 16'(sum)});
    e = exp_q[0];
    n_checks++;
    if (out_valid !== 1'b1 || out_result !== e[15:0] || out_ovf !== e[16] || in_ready !== 1'b0) begin
      n_fail++;
      $display("FAIL %s_result: out_valid=%b result=%h ovf=%b in_ready=%b, required 1 %h %b 0",
               name, out_valid, out_result, out_ovf, in_ready, e[15:0], e[16]);
    end
    for (int h = 0; h < hold; h++) begin
      start = 1'b1;
      abort = 1'b1;
      len   = 4'($urandom);
      tick();
      n_checks++;
      if (out_valid !== 1'b1 || out_result !== e[15:0] || out_ovf !== e[16] || cmd_ready !== 1'b0) begin
        n_fail++;
        $display("FAIL %s_hold%0d: out_valid=%b result=%h ovf=%b cmd_ready=%b, required 1 %h %b 0",
                 name, h, out_valid, out_result, out_ovf, cmd_ready, e[15:0], e[16]);
      end
    end
    abort = 1'b0;
    void'(exp_q.pop_front());
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    start = 1'b0;
    n_checks++;
    if (cmd_ready !== 1'b1 || out_valid !== 1'b0 || busy !== 1'b0) begin
      n_fail++;
      $display("FAIL %s_accept: cmd_ready=%b out_valid=%b busy=%b, required 1 0 0",
               name, cmd_ready, out_valid, busy);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    #2;
    check_reset_outputs("reset_initial");
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    check_reset_outputs("reset_released");
  endtask

  task automatic test_basic();
    pa[0] = 2; pb[0] = 3;
    pa[1] = 4; pb[1] = 5;
    pa[2] = 1; pb[2] = 1;
    run_dot(4'd3, 0, 0, "basic");
  endtask

  task automatic test_overflow();
    pa[0] = 255; pb[0] = 255;
    pa[1] = 255; pb[1] = 255;
    run_dot(4'd2, 0, 0, "ovf");
    pa[0] = 1; pb[0] = 1;
    run_dot(4'd1, 0, 0, "ovf_clear");
  endtask

  task automatic test_len_zero();
    for (int i = 0; i < 16; i++) begin
      pa[i] = 1;
      pb[i] = 2;
    end
    run_dot(4'd0, 1, 0, "len0");
  endtask

  task automatic test_abort();
    start = 1'b1;
    len   = 4'd3;
    tick();
    start = 1'b0;
    in_valid = 1'b1;
    in_a = 8'd3; in_b = 8'd4;
    tick();
    in_a = 8'd5; in_b = 8'd6;
    tick();
    in_a = 8'd9; in_b = 8'd9;
    abort = 1'b1;
    tick();
    abort = 1'b0;
    n_checks++;
    if (cmd_ready !== 1'b1 || busy !== 1'b0 || out_valid !== 1'b0 || out_result !== 16'd42) begin
      n_fail++;
      $display("FAIL abort: cmd_ready=%b busy=%b out_valid=%b result=%h, required 1 0 0 002a",
               cmd_ready, busy, out_valid, out_result);
    end
    for (int i = 0; i < 2; i++) begin
      tick();
      n_checks++;
      if (in_ready !== 1'b0 || out_valid !== 1'b0 || out_result !== 16'd42) begin
        n_fail++;
        $display("FAIL abort_idle%0d: in_ready=%b out_valid=%b result=%h, required 0 0 002a",
                 i, in_ready, out_valid, out_result);
      end
    end
    in_valid = 1'b0;
    pa[0] = 7; pb[0] = 7;
    run_dot(4'd1, 0, 0, "after_abort");
  endtask

  task automatic test_hold();
    pa[0] = 100; pb[0] = 200;
    pa[1] = 250; pb[1] = 240;
    pa[2] = 17;  pb[2] = 3;
    run_dot(4'd3, 0, 5, "hold");
  endtask

  task automatic test_async_reset();
    start = 1'b1;
    len   = 4'd5;
    tick();
    start = 1'b0;
    in_valid = 1'b1;
    in_a = 8'd10; in_b = 8'd10;
    tick();
    in_a = 8'd20; in_b = 8'd20;
    tick();
    in_valid = 1'b0;
    n_checks++;
    if (out_result !== 16'd500 || busy !== 1'b1) begin
      n_fail++;
      $display("FAIL areset_pre: result=%h busy=%b, required 01f4 1", out_result, busy);
    end
    #2;
    rst_n = 1'b0;
    #1;
    check_reset_outputs("areset_async");
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    check_reset_outputs("areset_released");
    pa[0] = 11; pb[0] = 13;
    pa[1] = 2;  pb[1] = 9;
    run_dot(4'd2, 0, 0, "after_areset");
  endtask

  task automatic test_random();
    for (int it = 0; it < 6; it++) begin
      for (int i = 0; i < 16; i++) begin
        pa[i] = int'($urandom_range(0, 255));
        pb[i] = int'($urandom_range(0, 255));
      end
      run_dot(4'($urandom_range(0, 15)), 2, int'($urandom_range(0, 2)), "random");
    end
  endtask

  task automatic test_back_to_back();
    pa[0] = 200; pb[0] = 200;
    pa[1] = 150; pb[1] = 180;
    run_dot(4'd2, 0, 0, "b2b_a");
    pa[0] = 9; pb[0] = 8;
    run_dot(4'd1, 0, 0, "b2b_b");
  endtask

  initial begin
    test_reset();
    test_basic();
    test_overflow();
    test_len_zero();
    test_abort();
    test_hold();
    test_async_reset();
    test_back_to_back();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/mac_dot_sequencer.md
MAC_DOT_SEQUENCER -- requirements
Module: mac_dot_sequencer

Interface
REQ-001 Parameter LEN_W, default 4, SHALL set the width of the vector-length command field.
REQ-002 clk  input  1  SHALL be the single clock; all state updates on its rising edge.
REQ-003 rst_n  input  1  SHALL be the reset: asynchronous, active-low.
REQ-004 start  input  1  SHALL request a new dot product; accepted only when cmd_ready=1.
REQ-005 len  input  LEN_W  SHALL give the pair count, sampled with start; 0 means 2^LEN_W pairs.
REQ-006 cmd_ready  output  1  SHALL be high only in IDLE.
REQ-007 abort  input  1  SHALL cancel an in-progress dot product.
REQ-008 in_valid / in_ready  input / output  1 each  SHALL form the operand handshake; a transfer occurs when both are high on a rising edge.
REQ-009 in_a, in_b  input  8 each  SHALL be unsigned operands, sampled on a transfer.
REQ-010 out_valid / out_ready  output / input  1 each  SHALL form the result handshake.
REQ-011 out_result  output  16  SHALL be the accumulated sum, modulo 2^16.
REQ-012 out_ovf  output  1  SHALL flag a carry out of bit 15 during the current dot product.
REQ-013 busy  output  1  SHALL be high in every state except IDLE.

Function
REQ-014 FSM states SHALL be IDLE, ACCUM and DONE.
REQ-015 IDLE: start=1 SHALL load the remaining count from len (0 -> 2^LEN_W), set the first flag, and move to ACCUM.
REQ-016 ACCUM: in_ready SHALL be 1; out_valid SHALL be 0.
REQ-017 First transfer SHALL load acc <= in_a*in_b and clear ovf (clear-and-multiply).
REQ-018 Later transfers SHALL update acc <= acc + in_a*in_b (16-bit wrap); a carry out of bit 15 SHALL set sticky ovf.
REQ-019 Cycles without a transfer SHALL leave acc, ovf and the count unchanged.
REQ-020 The transfer that takes the count to zero SHALL move the FSM to DONE; out_valid SHALL be high in the next cycle with the final acc (1-cycle latency).
REQ-021 DONE: out_result and out_ovf SHALL be held stable while out_valid=1 and out_ready=0; in_ready SHALL be 0.
REQ-022 DONE with out_ready=1 SHALL return the FSM to IDLE; a new start SHALL be accepted no earlier than the following cycle.
REQ-023 abort=1 in ACCUM SHALL return the FSM to IDLE with no result and no operand transfer that cycle; abort SHALL take priority over in_valid.
REQ-024 abort SHALL be ignored in IDLE and DONE; start SHALL be ignored outside IDLE.
REQ-025 A transfer on the last pair SHALL count before abort only if abort=0 that cycle.
REQ-026 8x8 products SHALL be exact (16 bits unsigned); no saturation.

Reset
REQ-027 rst_n low SHALL immediately force IDLE, acc=0, ovf=0, count=0, first=0.
REQ-028 Outputs during reset SHALL be cmd_ready=1, in_ready=0, out_valid=0, busy=0, out_result=0, out_ovf=0.
REQ-029 Reset mid-ACCUM or mid-DONE SHALL discard the partial or pending result.

Structure
REQ-030 Shared package SHALL hold the FSM state encoding, the operand width (8) and the result width (16).
REQ-031 A sub-module mac_unit (inputs en, clr_mult, a, b; outputs acc[15:0], ovf) SHALL hold the accumulator; the FSM SHALL drive en=transfer and clr_mult=first.

Verification
REQ-032 start, len=3; pairs (2,3),(4,5),(1,1) back-to-back -> out_valid 1 cycle after the 3rd transfer, out_result=27, out_ovf=0.
REQ-033 len=2; pairs (255,255),(255,255) -> out_result=0xFC02, out_ovf=1; next len=1 pair (1,1) -> out_result=1, out_ovf=0.
REQ-034 len=0; 16 pairs of (1,2), with in_valid low every other cycle -> out_result=32; acc unchanged on idle cycles.
REQ-035 len=3; 2 transfers then abort with in_valid=1 -> FSM to IDLE, no out_valid; new len=1 pair (7,7) -> out_result=49.
REQ-036 Result ready; hold out_ready=0 for 5 cycles -> out_result/out_ovf stable and start ignored; out_ready=1 -> IDLE next cycle.
REQ-037 Assert rst_n low mid-ACCUM between edges -> outputs reach reset values without a clock edge.
